// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller
//  Description : MEM-stage data port that splits each 32-bit load/store into
//                two 16-bit accesses on an asynchronous SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_controller #(
    parameter int WORD_LEN  = 32,
    parameter int SRAM_WAIT = 1,
    parameter int DATA_BASE = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdEn,
    input  logic                wrEn,
    input  logic [WORD_LEN-1:0] address,
    input  logic [WORD_LEN-1:0] writeData,
    output logic [WORD_LEN-1:0] readData,
    output logic                ready,
    output logic [17:0]         SRAM_ADDR,
    inout  wire  [15:0]         SRAM_DQ,
    output logic                SRAM_WE_N
);

    localparam logic [2:0] C_WAIT_LAST = 3'(SRAM_WAIT);
    localparam logic       C_HAS_HOLD  = (SRAM_WAIT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                is_wr_q, is_wr_d;
    logic [16:0]         index_q, index_d;
    logic [WORD_LEN-1:0] wdata_q, wdata_d;
    logic [2:0]          wait_q, wait_d;
    logic [WORD_LEN-1:0] read_data_q, read_data_d;

    logic                w_last;
    logic                w_dq_oe;
    logic [15:0]         w_dq_out;

    assign w_last = (wait_q == C_WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        index_d     = index_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        read_data_d = read_data_q;
        SRAM_ADDR   = 18'd0;
        SRAM_WE_N   = 1'b1;
        w_dq_oe     = 1'b0;
        w_dq_out    = 16'h0000;

        case (state_q)
            IDLE: begin
                if (wrEn || rdEn) begin
                    is_wr_d = wrEn;
                    index_d = 17'((address - WORD_LEN'(DATA_BASE)) >> 2);
                    wdata_d = writeData;
                    wait_d  = 3'd0;
                    state_d = LO;
                end
            end
            LO, HI: begin
                SRAM_ADDR = {index_q, (state_q == HI)};
                if (is_wr_q) begin
                    // Releasing WE_N one cycle early keeps data stable past the write edge.
                    w_dq_oe   = 1'b1;
                    w_dq_out  = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
                    SRAM_WE_N = w_last && C_HAS_HOLD;
                end else if (w_last) begin
                    if (state_q == HI) begin
                        read_data_d[31:16] = SRAM_DQ;
                    end else begin
                        read_data_d[15:0] = SRAM_DQ;
                    end
                end
                if (w_last) begin
                    wait_d  = 3'd0;
                    state_d = (state_q == HI) ? DONE : HI;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            index_q     <= 17'd0;
            wdata_q     <= '0;
            wait_q      <= 3'd0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            index_q     <= index_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            read_data_q <= read_data_d;
        end
    end

    assign SRAM_DQ  = w_dq_oe ? w_dq_out : 16'hzzzz;
    assign readData = read_data_q;
    assign ready    = !((rdEn || wrEn) && (state_q != DONE));

endmodule
`default_nettype wire

// File: doc/sram_controller.md
# sram_controller

Multi-cycle data-memory port for the MEM stage. It turns a 32-bit MEM-stage load or store into two 16-bit accesses on an external asynchronous SRAM. While an access is in flight it holds the pipeline with `ready` low. It produces the `memReadVal` word that the MEM-to-WB pipeline register captures, so it is the producing end of the MEM-to-WB interface.

## Interface
Parameters:
- `SRAM_WAIT`, default 1: extra wait cycles per 16-bit half access (legal range 0–7).
- `DATA_BASE`, default 1024: byte address mapped to SRAM word 0.

Ports (reset is synchronous, active-high; everything is in the `clk` domain):
- `clk`, input, 1: the single clock, rising edge.
- `rst`, input, 1: synchronous active-high reset.
- `rdEn`, input, 1: MEM-stage load request.
- `wrEn`, input, 1: MEM-stage store request; has priority when both it and `rdEn` are high.
- `address`, input, `WORD_LEN`: byte address (ALU result).
- `writeData`, input, `WORD_LEN`: store data.
- `readData`, output, `WORD_LEN`: load result, feeds the MEM-to-WB register input.
- `ready`, output, 1: low means freeze every pipeline register and the PC.
- `SRAM_ADDR`, output, 18: SRAM half-word address.
- `SRAM_DQ`, inout, 16: SRAM data bus.
- `SRAM_WE_N`, output, 1: active-low write enable.

## Operation
- States are IDLE, LO, HI and DONE.
- The request is sampled only in IDLE.
- IDLE:
  - If `wrEn|rdEn`, latch the operation (write if `wrEn`), `address` and `writeData`, clear the wait counter, and go to LO.
  - Otherwise stay in IDLE.
- Address mapping: word index = (`address` − `DATA_BASE`) >> 2, truncated to 17 bits.
  - LO drives `SRAM_ADDR` = {index, 0}; HI drives {index, 1}.
  - Low bits [1:0] of `address` are ignored.
- Each of LO and HI lasts exactly `SRAM_WAIT`+1 cycles, counted by a wait counter that clears on entering each phase.
- Write in LO:
  - `SRAM_DQ` is driven with `writeData[15:0]`.
  - `SRAM_WE_N` is 0 for every cycle of the phase except the last, where it is 1. This gives hold time.
  - When `SRAM_WAIT`=0 the single cycle has `SRAM_WE_N`=0.
- Write in HI: same as LO, using `writeData[31:16]`.
- Read:
  - `SRAM_DQ` is high-Z and `SRAM_WE_N`=1.
  - The last cycle of LO samples `SRAM_DQ` into `readData[15:0]`; the last cycle of HI samples it into `readData[31:16]`.
- DONE: one cycle, then IDLE.
- `ready` is combinational: 0 when (`rdEn|wrEn`) is high and the state is not DONE; 1 otherwise.
- `readData` holds its value until the next read overwrites it. Writes never change it.
- Outside a write phase `SRAM_DQ` is high-Z and `SRAM_WE_N`=1.
- `SRAM_ADDR` is 0 in IDLE and DONE.
- A request dropped mid-access does not abort: the access completes and DONE is still visited.
- In DONE the current request is not re-sampled, so a back-to-back request starts in the following IDLE cycle.

## Timing
- Reset values: state IDLE, `readData`=0, `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_DQ` high-Z, wait counter 0. `ready` is then 1 if there is no request and 0 if a request is present.
- Latency (C0 = cycle the request is first seen in IDLE):
  - LO occupies C1..C(`SRAM_WAIT`+1).
  - HI occupies the next `SRAM_WAIT`+1 cycles.
  - DONE is cycle 2·(`SRAM_WAIT`+1)+1, with `ready`=1 and `readData` valid.
  - Default: DONE is C5, so the pipeline is frozen 5 cycles.
- `rst` asserted in any state forces the reset values on the next edge. The write is aborted; the SRAM may hold a partial word.
- The MEM-to-WB register captures `readData` on the edge ending DONE.

## Test plan
- Store 0xDEADBEEF to 1024 with `SRAM_WAIT`=1 -> SRAM half-word 0 = 0xBEEF and half-word 1 = 0xDEAD; `ready` is 0 in C0–C4 and 1 in C5.
- Load from 1024 after the store (SRAM model returns the stored halves) -> `readData`=0xDEADBEEF in C5 and held afterwards; `SRAM_WE_N` is 1 throughout.
- Store 0x12345678 to 1028 then to 1031 -> both use `SRAM_ADDR` 2 and 3; the second overwrites with the same mapping.
- No request for 10 cycles -> `ready`=1, `SRAM_WE_N`=1, `SRAM_DQ`=Z, `SRAM_ADDR`=0.
- `rst` pulsed during HI of a store -> next cycle IDLE, `SRAM_WE_N`=1, `readData`=0; half-word 1 is not written if the pulse arrives in the first HI cycle.
- `SRAM_WAIT`=0 with back-to-back load, store and load -> each access takes 4 cycles (C0 IDLE, C1 LO, C2 HI, C3 DONE); the second request is sampled in the cycle after DONE.
